// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I multicycle controller: FSM states, opcodes and ALU codes.
package riscv_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StJal      = 4'd9,
        StBeq      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps ALUOp plus instruction function fields to the 4-bit ALU control code.
module mc_aludec
    import riscv_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [3:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type subtracts; addi with imm[10]=1 must still add.
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alucontrol = ALU_SLL;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b011:  alucontrol = ALU_SLTU;
                    3'b100:  alucontrol = ALU_XOR;
                    3'b101:  alucontrol = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alucontrol = ALU_OR;
                    default: alucontrol = ALU_AND;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle RV32I control FSM sharing one memory port for fetch and data.
// Optional macro MC_BNE_EN adds bne (funct3=001) support in the branch state.
module riscv_mc_controller
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       RegWrite
);

    state_e     state_q, state_d;
    logic [1:0] aluop;
    logic       pcupdate;
    logic       branch;
    logic       taken;
    logic       irwrite_s;
    logic       memwrite_s;
    logic       regwrite_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = StFetch;
        aluop      = ALUOP_ADD;
        pcupdate   = 1'b0;
        branch     = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        case (state_q)
            StFetch: begin
                irwrite_s = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pcupdate  = 1'b1;
                state_d   = StDecode;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = StMemAdr;
                    OP_R:              state_d = StExecuteR;
                    OP_I:              state_d = StExecuteI;
                    OP_JAL:            state_d = StJal;
                    OP_BRANCH:         state_d = StBeq;
                    default:           state_d = StFetch;
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LOAD) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                AdrSrc  = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc  = 2'b01;
                regwrite_s = 1'b1;
            end
            StMemWrite: begin
                AdrSrc     = 1'b1;
                memwrite_s = 1'b1;
            end
            StExecuteR: begin
                ALUSrcA = 2'b10;
                aluop   = ALUOP_FUNCT;
                state_d = StAluWb;
            end
            StExecuteI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                aluop   = ALUOP_FUNCT;
                state_d = StAluWb;
            end
            StAluWb: begin
                regwrite_s = 1'b1;
            end
            StJal: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                pcupdate = 1'b1;
                state_d  = StAluWb;
            end
            StBeq: begin
                ALUSrcA = 2'b10;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
            end
            default: state_d = StFetch;
        endcase
    end

    // Branch resolution is Mealy on Zero; only consulted while branch is set.
    always_comb begin
        taken = 1'b0;
        if (funct3 == 3'b000) begin
            taken = Zero;
        end
`ifdef MC_BNE_EN
        else if (funct3 == 3'b001) begin
            taken = ~Zero;
        end
`endif
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

    // Reset suppresses every datapath write so an aborted instruction leaves no trace.
    assign PCWrite  = ~reset & (pcupdate | (branch & taken));
    assign IRWrite  = ~reset & irwrite_s;
    assign MemWrite = ~reset & memwrite_s;
    assign RegWrite = ~reset & regwrite_s;

    mc_aludec u_aludec (
        .aluop      (aluop),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .alucontrol (ALUControl)
    );

endmodule

// File: doc/riscv_mc_controller.md
# riscv_mc_controller

Multicycle control unit for the RV32I core. It replaces the single-cycle decoder when instruction fetch and data access share one memory port. A Moore FSM (plus a Mealy branch term) sequences the datapath one micro-step per cycle, driving register enables, mux selects and the 4-bit ALU control code.

## Interface
- No parameters; widths are fixed by the RV32I encoding.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `op`  in  7  `Instr[6:0]`, taken from the instruction register.
- `funct3`  in  3  `Instr[14:12]`.
- `funct7b5`  in  1  `Instr[30]`.
- `Zero`  in  1  ALU zero flag.
- `PCWrite`  out  1  PC register enable.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = Result.
- `MemWrite`  out  1  memory write strobe.
- `IRWrite`  out  1  captures the instruction register and OldPC.
- `ResultSrc`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rd1 register.
- `ALUSrcB`  out  2  ALU B select: 00 = rd2 register, 01 = ImmExt, 10 = constant 4.
- `ImmSrc`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `ALUControl`  out  4  ALU operation code; see Operation.
- `RegWrite`  out  1  register file write enable.

## Operation
- State register is 4 bits. Encoding:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5
  - EXECUTER 6, EXECUTEI 7, ALUWB 8, JAL 9, BEQ 10
  - Codes 11–15 are unused and go to FETCH on the next cycle with all strobes at 0.
- Unlisted outputs are 0 in every state. Signals used below:
  - ALUOp: 00 = add, 01 = sub, 10 = funct decode.
  - PCUpdate and Branch are internal.
- Per-state outputs and next state:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next by op:
    - 0000011 / 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1101111 → JAL
    - 1100011 → BEQ
    - any other op → FETCH (illegal op, no side effects)
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
- `PCWrite = PCUpdate | (Branch & taken)`. The taken term is Mealy on `Zero`; `taken = Zero` for funct3=000.
- ImmSrc is combinational from `op`, independent of state:
  - I-type and load → 00
  - store → 01
  - branch → 10
  - jal → 11
  - anything else → 00
- ALUControl codes: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sll 0110, srl 0111, sra 1000, sltu 1001.
- ALUControl decode:
  - ALUOp=00 → add; ALUOp=01 → sub.
  - ALUOp=10 decodes funct3:
    - 000 → sub if `op[5] & funct7b5`, else add
    - 001 → sll; 010 → slt; 011 → sltu; 100 → xor
    - 101 → sra if `funct7b5`, else srl
    - 110 → or; 111 → and

## Timing
- The next state is registered on the rising edge of `clk`; all outputs are combinational from the state (plus `Zero` and `op` where stated above).
- Cycles per instruction, counted from FETCH: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, illegal 2.
- Reset:
  - While `reset`=1: PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - On the first edge with `reset`=1, state becomes FETCH.
  - After the first edge, all other outputs show FETCH values.
  - Reset asserted mid-instruction aborts it: no write strobe reaches the datapath in the reset cycle.
- `Zero` is sampled only in the BEQ state; `Zero` toggling in any other state has no effect.

## Configuration
- `MC_BNE_EN` defined: in the BEQ state, funct3=001 gives `taken = ~Zero`.
- Undefined: any branch with funct3≠000 is never taken, but still spends 3 cycles.

## Structure
- Package `riscv_pkg` holds:
  - the state encoding
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_BRANCH)
  - the ALUControl codes
- Sub-module `mc_aludec`: combinational (ALUOp, funct3, op[5], funct7b5) → ALUControl. The FSM, next-state logic and ImmSrc decode stay in the top.

## Test plan
- Reset held 2 cycles, then an add instruction (op=0110011, funct3=000, funct7b5=0) → during reset all strobes are 0. States run FETCH, DECODE, EXECUTER, ALUWB; RegWrite=1 only in the 4th cycle; ALUControl=0000 in EXECUTER.
- lw (op=0000011) → 5 cycles. AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB; ImmSrc=00 throughout.
- sw (op=0100011) → MemWrite=1 for exactly one cycle (cycle 4); ImmSrc=01; never RegWrite.
- beq with Zero=1, then with Zero=0 → PCWrite=1 in the BEQ cycle only when Zero=1. With `MC_BNE_EN` and funct3=001, the result is inverted.
- sub (funct7b5=1) and srai (op=0010011, funct3=101, funct7b5=1) → ALUControl 0001 and 1000. addi with funct7b5=1 gives 0000.
- Illegal op=1111111 → DECODE returns to FETCH with no strobes asserted. Reset asserted in the MEMWRITE cycle → MemWrite=0 and state=FETCH next cycle.
